mul_arbiter: RTL and testbench

Round-robin arbiter that shares one multi-cycle `mul` unit (16-bit operands, 32-bit product, val/rdy on request and response) among `p_nreqs` requesters. It sits between the requesting tiles and the single `mul` instance. A per-grant tag FIFO records which requester issued each operation, and each in-order `mul` response is steered back to that requester. The arbiter adds no latency on either the request or the response path.

---
 rtl/mul_arb_pkg.sv | 30 +++
 rtl/mul_arb_checker.sv | 26 ++
 rtl/mul_arb_tag_fifo.sv | 68 ++++++
 rtl/mul_arbiter.sv | 131 +++++++++++++
 tb/tb_mul_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_arb_pkg.sv
// Shared types, default sizes and small helpers for the mul arbiter slice.
package mul_arb_pkg;

    localparam int c_nreqs = 4;
    localparam int c_width = 16;
    localparam int c_depth = 4;
    localparam int c_id_w  = $clog2(c_nreqs);

    // Requester id at the default requester count.
    typedef logic [c_id_w-1:0] id_t;

    // Operand pair as carried on a request message: {a, b}.
    typedef struct packed {
        logic [c_width-1:0] a;
        logic [c_width-1:0] b;
    } operands_t;

    // Product as carried on a response message.
    typedef logic [2*c_width-1:0] product_t;

    // Round-robin successor of an id, wrapping at n.
    function automatic int next_id(input int id, input int n);
        if (id + 1 >= n) begin
            return 0;
        end else begin
            return id + 1;
        end
    endfunction

endpackage

// File: rtl/mul_arb_checker.sv
// Simulation-only protocol and consistency checks for the mul arbiter.
module mul_arb_checker #(
    parameter int p_depth  = 4,
    parameter int p_cnt_w  = 3
) (
    input logic               clk,
    input logic               reset,
    input logic               mul_resp_val,
    input logic               empty,
    input logic               full,
    input logic [p_cnt_w-1:0] count
);

    // mul must never answer when no operation is in flight.
    a_resp_when_empty: assert property (@(posedge clk) disable iff (!reset)
        !(mul_resp_val && empty));

    // Occupancy never exceeds the FIFO depth.
    a_count_bound: assert property (@(posedge clk) disable iff (!reset)
        count <= p_cnt_w'(p_depth));

    // Full flag tracks the count exactly.
    a_full_flag: assert property (@(posedge clk) disable iff (!reset)
        full == (count == p_cnt_w'(p_depth)));

endmodule

// File: rtl/mul_arb_tag_fifo.sv
// Tag FIFO holding the requester id of each operation in flight inside mul.
module mul_arb_tag_fifo #(
    parameter  int p_depth  = 4,
    parameter  int p_id_w   = 2,
    localparam int lp_ptr_w = $clog2(p_depth),
    localparam int lp_cnt_w = $clog2(p_depth) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_push,
    input  logic [p_id_w-1:0]   i_push_id,
    input  logic                i_pop,
    output logic [p_id_w-1:0]   o_head_id,
    output logic                o_full,
    output logic                o_empty,
    output logic [lp_cnt_w-1:0] o_count
);

    localparam logic [lp_cnt_w-1:0] lp_full_cnt = lp_cnt_w'(p_depth);

    logic [p_id_w-1:0]   r_mem [p_depth];
    logic [lp_ptr_w-1:0] r_head;
    logic [lp_ptr_w-1:0] r_tail;
    logic [lp_cnt_w-1:0] r_count;
    logic                w_push;
    logic                w_pop;

    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign w_push    = i_push & ~o_full;
    assign w_pop     = i_pop & ~o_empty;
    assign o_full    = (r_count == lp_full_cnt);
    assign o_empty   = (r_count == {lp_cnt_w{1'b0}});
    assign o_count   = r_count;
    assign o_head_id = r_mem[r_head];

    // Storage write at the tail; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < p_depth; i++) begin
                r_mem[i] <= {p_id_w{1'b0}};
            end
        end else if (w_push) begin
            r_mem[r_tail] <= i_push_id;
        end
    end

    // Head/tail pointers and occupancy count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= {lp_ptr_w{1'b0}};
            r_tail  <= {lp_ptr_w{1'b0}};
            r_count <= {lp_cnt_w{1'b0}};
        end else begin
            if (w_push) begin
                r_tail <= r_tail + lp_ptr_w'(1);
            end
            if (w_pop) begin
                r_head <= r_head + lp_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + lp_cnt_w'(1);
                2'b01:   r_count <= r_count - lp_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one multi-cycle mul unit among several requesters,
// steering each in-order response back to the requester that issued it.
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int p_nreqs = c_nreqs,
    parameter int p_width = c_width,
    parameter int p_depth = c_depth
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [p_nreqs-1:0]           in_req_val,
    output logic [p_nreqs-1:0]           in_req_rdy,
    input  logic [p_nreqs*2*p_width-1:0] in_req_msg,
    output logic [p_nreqs-1:0]           in_resp_val,
    input  logic [p_nreqs-1:0]           in_resp_rdy,
    output logic [2*p_width-1:0]         in_resp_msg,
    output logic                         mul_req_val,
    input  logic                         mul_req_rdy,
    output logic [2*p_width-1:0]         mul_req_msg,
    input  logic                         mul_resp_val,
    output logic                         mul_resp_rdy,
    input  logic [2*p_width-1:0]         mul_resp_msg
);

    localparam int lp_id_w  = $clog2(p_nreqs);
    localparam int lp_msg_w = 2 * p_width;
    localparam int lp_cnt_w = $clog2(p_depth) + 1;

    logic [lp_id_w-1:0]  r_ptr;
    logic [lp_id_w-1:0]  w_grant;
    logic [lp_id_w-1:0]  w_head;
    logic                w_any;
    logic                w_full;
    logic                w_empty;
    logic                w_issue;
    logic                w_resp_fire;
    logic [lp_cnt_w-1:0] w_count;

    // Grant search: first valid requester starting at the priority pointer.
    always_comb begin
        int   v_idx;
        logic v_found;
        v_idx   = 0;
        v_found = 1'b0;
        w_grant = r_ptr;
        for (int k = 0; k < p_nreqs; k++) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= p_nreqs) begin
                v_idx = v_idx - p_nreqs;
            end else begin
                v_idx = v_idx;
            end
            if (!v_found && in_req_val[v_idx]) begin
                w_grant = lp_id_w'(v_idx);
                v_found = 1'b1;
            end else begin
                v_found = v_found;
            end
        end
    end

    // Request path is purely combinational; reset masks it so nothing issues.
    assign w_any       = |in_req_val;
    assign mul_req_val = reset & w_any & ~w_full;
    assign w_issue     = mul_req_val & mul_req_rdy;
    assign mul_req_msg = in_req_msg[int'(w_grant)*lp_msg_w +: lp_msg_w];

    // Only the granted requester sees ready, and only when the issue fires.
    always_comb begin
        in_req_rdy = {p_nreqs{1'b0}};
        if (w_issue) begin
            in_req_rdy[w_grant] = 1'b1;
        end else begin
            in_req_rdy = {p_nreqs{1'b0}};
        end
    end

    // Response steering to the requester recorded at the FIFO head.
    always_comb begin
        in_resp_val = {p_nreqs{1'b0}};
        if (reset && mul_resp_val && !w_empty) begin
            in_resp_val[w_head] = 1'b1;
        end else begin
            in_resp_val = {p_nreqs{1'b0}};
        end
    end

    assign mul_resp_rdy = reset & in_resp_rdy[w_head] & ~w_empty;
    assign in_resp_msg  = mul_resp_msg;
    assign w_resp_fire  = mul_resp_val & mul_resp_rdy;

    // Priority pointer moves past the winner on every issue, else holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= {lp_id_w{1'b0}};
        end else if (w_issue) begin
            r_ptr <= lp_id_w'(next_id(int'(w_grant), p_nreqs));
        end else begin
            r_ptr <= r_ptr;
        end
    end

    mul_arb_tag_fifo #(
        .p_depth (p_depth),
        .p_id_w  (lp_id_w)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_issue),
        .i_push_id (w_grant),
        .i_pop     (w_resp_fire),
        .o_head_id (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    mul_arb_checker #(
        .p_depth (p_depth),
        .p_cnt_w (lp_cnt_w)
    ) u_chk (
        .clk          (clk),
        .reset        (reset),
        .mul_resp_val (mul_resp_val),
        .empty        (w_empty),
        .full         (w_full),
        .count        (w_count)
    );

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: queue-based reference model plus a
// behavioural mul unit, directed scenarios and a random soak.
module tb_mul_arbiter;
    import mul_arb_pkg::*;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int MW = 32;

    logic            clk;
    logic            reset;
    logic [N-1:0]    in_req_val;
    logic [N-1:0]    in_req_rdy;
    logic [N*MW-1:0] in_req_msg;
    logic [N-1:0]    in_resp_val;
    logic [N-1:0]    in_resp_rdy;
    logic [MW-1:0]   in_resp_msg;
    logic            mul_req_val;
    logic            mul_req_rdy;
    logic [MW-1:0]   mul_req_msg;
    logic            mul_resp_val;
    logic            mul_resp_rdy;
    logic [MW-1:0]   mul_resp_msg;

    mul_arbiter #(.p_nreqs(N), .p_width(16), .p_depth(D)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_req_val   (in_req_val),
        .in_req_rdy   (in_req_rdy),
        .in_req_msg   (in_req_msg),
        .in_resp_val  (in_resp_val),
        .in_resp_rdy  (in_resp_rdy),
        .in_resp_msg  (in_resp_msg),
        .mul_req_val  (mul_req_val),
        .mul_req_rdy  (mul_req_rdy),
        .mul_req_msg  (mul_req_msg),
        .mul_resp_val (mul_resp_val),
        .mul_resp_rdy (mul_resp_rdy),
        .mul_resp_msg (mul_resp_msg)
    );

    always #5 clk = ~clk;

    typedef struct { int id; logic [31:0] prod; } tag_t;
    typedef struct { logic [31:0] prod; int rdy_cyc; } pipe_t;

    tag_t        tq[$];     // model: operations in flight, issue order
    pipe_t       pq[$];     // behavioural mul pipeline
    tag_t        rx[$];     // deliveries seen on the DUT outputs
    int          iss[$];    // granted ids in issue order
    logic [31:0] src[N][$]; // per-requester pending operand pairs

    int  mp, cyc, n_tests, n_fail;
    bit  rand_mode, mreq_rdy_cfg;
    logic [N-1:0] resp_rdy_cfg;

    bit          s_req_fire, s_resp_fire;
    int          s_grant;
    logic [31:0] s_req_msg;
    logic        obs_mrv, obs_mrsp_val, obs_mrsp_rdy;
    logic [N-1:0] obs_irv;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input int a, input int b);
        operands_t op;
        op.a = 16'(a);
        op.b = 16'(b);
        return op;
    endfunction

    function automatic logic [31:0] prodof(input logic [31:0] m);
        operands_t op;
        op = m;
        return 32'(op.a) * 32'(op.b);
    endfunction

    // Drive requester and mul-side inputs for the coming cycle.
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bit gate;
            gate = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            in_req_val[i] = (src[i].size() > 0) && gate;
            in_req_msg[i*MW +: MW] = (src[i].size() > 0) ? src[i][0] : 32'h0;
        end
        in_resp_rdy  = rand_mode ? N'($urandom) : resp_rdy_cfg;
        mul_req_rdy  = rand_mode ? 1'($urandom_range(0, 1)) : mreq_rdy_cfg;
        mul_resp_val = (pq.size() > 0) && (pq[0].rdy_cyc <= cyc) &&
                       (!rand_mode || ($urandom_range(0, 3) != 0));
        mul_resp_msg = (pq.size() > 0) ? pq[0].prod : 32'h0;
    endtask

    // Compare every DUT output against the model for this cycle.
    task automatic check();
        int g;
        bit found, e_mrv, e_mrr;
        logic [N-1:0] e_rdy, e_irv;
        g = 0;
        found = 0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (mp + k) % N;
            if (!found && in_req_val[idx]) begin
                g = idx;
                found = 1;
            end
        end
        e_mrv = reset && (in_req_val != '0) && (tq.size() < D);
        e_rdy = (e_mrv && mul_req_rdy) ? N'(1) << g : '0;
        e_irv = (reset && tq.size() > 0 && mul_resp_val) ? N'(1) << tq[0].id : '0;
        e_mrr = reset && (tq.size() > 0) && in_resp_rdy[tq[0].id];
        chk("mul_req_val", mul_req_val, e_mrv);
        chk("in_req_rdy", in_req_rdy, e_rdy);
        if (e_mrv) chk("mul_req_msg", mul_req_msg, in_req_msg[g*MW +: MW]);
        chk("in_resp_val", in_resp_val, e_irv);
        chk("mul_resp_rdy", mul_resp_rdy, e_mrr);
        chk("in_resp_msg", in_resp_msg, mul_resp_msg);
        s_req_fire  = e_mrv && mul_req_rdy;
        s_grant     = g;
        s_req_msg   = in_req_msg[g*MW +: MW];
        s_resp_fire = e_mrr && mul_resp_val;
        if (s_resp_fire) chk("resp_data", in_resp_msg, tq[0].prod);
        for (int i = 0; i < N; i++) begin
            if (in_resp_val[i] && in_resp_rdy[i]) rx.push_back('{i, in_resp_msg});
        end
        obs_mrv      = mul_req_val;
        obs_mrsp_val = mul_resp_val;
        obs_mrsp_rdy = mul_resp_rdy;
        obs_irv      = in_resp_val;
    endtask

    // Advance model and behavioural mul at the clock edge.
    task automatic update();
        if (!reset) begin
            tq.delete();
            pq.delete();
            mp = 0;
        end else begin
            if (s_resp_fire) begin
                void'(tq.pop_front());
                void'(pq.pop_front());
            end
            if (s_req_fire) begin
                tq.push_back('{s_grant, prodof(s_req_msg)});
                pq.push_back('{prodof(s_req_msg), cyc + 3});
                mp = (s_grant + 1) % N;
                void'(src[s_grant].pop_front());
                iss.push_back(s_grant);
            end
        end
        cyc++;
    endtask

    task automatic tick();
        drive();
        @(negedge clk);
        check();
        @(posedge clk);
        update();
        #1;
    endtask

    task automatic run_until(input int nrx, input int budget, input string name);
        int k;
        k = 0;
        while (rx.size() < nrx && k < budget) begin
            tick();
            k++;
        end
        chk(name, rx.size(), nrx);
    endtask

    task automatic chk_rx(input int k, input int id, input logic [31:0] data);
        if (k < rx.size()) begin
            chk("rx_id", rx[k].id, id);
            chk("rx_data", rx[k].prod, data);
        end else begin
            chk("rx_missing", rx.size(), k + 1);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int i = 0; i < N; i++) src[i].delete();
        tick();
        tick();
        reset = 1'b1;
        rx.delete();
        iss.delete();
    endtask

    initial begin
        int n0;
        logic [31:0] exp_r[N][$];
        clk = 1'b0; reset = 1'b0; cyc = 0; mp = 0; n_tests = 0; n_fail = 0;
        rand_mode = 0; mreq_rdy_cfg = 1'b1; resp_rdy_cfg = '1;
        in_req_val = '1; in_req_msg = '0; in_resp_rdy = '1;
        mul_req_rdy = 1'b1; mul_resp_val = 1'b0; mul_resp_msg = '0;
        #1;
        chk("rst_mul_req_val", mul_req_val, 1'b0);
        chk("rst_in_req_rdy", in_req_rdy, 4'b0000);
        chk("rst_in_resp_val", in_resp_val, 4'b0000);
        chk("rst_mul_resp_rdy", mul_resp_rdy, 1'b0);
        chk("rst_count", dut.w_count, 3'd0);
        tick();
        tick();
        reset = 1'b1;

        // Single requester
        src[0].push_back(mk(5, 10));
        src[0].push_back(mk(18, 14));
        run_until(2, 40, "t1_done");
        chk_rx(0, 0, 32'd50);
        chk_rx(1, 0, 32'd252);

        // All four requesters valid from reset
        do_reset();
        for (int i = 0; i < N; i++) begin
            src[i].push_back(mk(i + 1, 3));
            src[i].push_back(mk(i + 1, 3));
        end
        run_until(8, 100, "t2_done");
        for (int k = 0; k < 5; k++) begin
            if (k < iss.size()) chk("t2_grant", iss[k], k % 4);
            else chk("t2_grant_missing", iss.size(), 5);
        end
        chk_rx(0, 0, 32'd3);
        chk_rx(1, 1, 32'd6);
        chk_rx(2, 2, 32'd9);
        chk_rx(3, 3, 32'd12);
        chk_rx(4, 0, 32'd3);

        // FIFO fills with responses stalled; no bypass on full
        do_reset();
        resp_rdy_cfg = 4'b0000;
        for (int i = 0; i < 6; i++) src[1].push_back(mk(i + 2, 5));
        n0 = iss.size();
        repeat (10) tick();
        chk("t3_issues", iss.size() - n0, 4);
        chk("t3_blocked", obs_mrv, 1'b0);
        resp_rdy_cfg = 4'b1111;
        tick();
        chk("t3_no_bypass", obs_mrv, 1'b0);
        chk("t3_pop", obs_mrsp_val && obs_mrsp_rdy, 1'b1);
        tick();
        chk("t3_resume", obs_mrv, 1'b1);
        run_until(6, 100, "t3_done");
        chk_rx(0, 1, 32'd10);
        chk_rx(5, 1, 32'd35);

        // Backpressure at the owning requester
        do_reset();
        resp_rdy_cfg = 4'b1011;
        src[2].push_back(mk(7, 6));
        repeat (8) tick();
        chk("t4_mul_resp_val", obs_mrsp_val, 1'b1);
        chk("t4_mul_resp_rdy", obs_mrsp_rdy, 1'b0);
        chk("t4_in_resp_val", obs_irv, 4'b0100);
        chk("t4_nothing_rx", rx.size(), 0);
        resp_rdy_cfg = 4'b1111;
        run_until(1, 20, "t4_done");
        chk_rx(0, 2, 32'd42);

        // Reset with two operations in flight
        do_reset();
        src[0].push_back(mk(2, 2));
        src[1].push_back(mk(4, 4));
        src[3].push_back(mk(9, 9));
        tick();
        tick();
        chk("t5_count_pre", dut.w_count, 3'd2);
        chk("t5_mrv_pre", mul_req_val, 1'b1);
        reset = 1'b0;
        #1;
        chk("t5_mul_req_val", mul_req_val, 1'b0);
        chk("t5_in_req_rdy", in_req_rdy, 4'b0000);
        chk("t5_in_resp_val", in_resp_val, 4'b0000);
        chk("t5_mul_resp_rdy", mul_resp_rdy, 1'b0);
        chk("t5_count_rst", dut.w_count, 3'd0);
        for (int i = 0; i < N; i++) src[i].delete();
        tick();
        tick();
        reset = 1'b1;
        rx.delete();
        iss.delete();
        src[2].push_back(mk(3, 13));
        run_until(1, 30, "t5_done");
        chk_rx(0, 2, 32'd39);
        repeat (4) tick();
        chk("t5_rx_count", rx.size(), 1);
        chk("t5_count_end", dut.w_count, 3'd0);

        // Random soak
        do_reset();
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 100; k++) begin
                logic [31:0] m;
                m = mk($urandom_range(0, 255), $urandom_range(0, 255));
                src[i].push_back(m);
                exp_r[i].push_back(prodof(m));
            end
        end
        rand_mode = 1;
        run_until(400, 20000, "t6_done");
        rand_mode = 0;
        for (int i = 0; i < N; i++) begin
            int got, bad;
            got = 0;
            bad = 0;
            foreach (rx[k]) begin
                if (rx[k].id == i) begin
                    if (got >= exp_r[i].size() || rx[k].prod !== exp_r[i][got]) bad++;
                    got++;
                end
            end
            chk("t6_rx_per_req", got, 100);
            chk("t6_bad_per_req", bad, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
